password_lock_ctrl: RTL

//  Session controller that sequences the 4-digit password checker FSM.

---
 rtl/password_lock_ctrl_pkg.sv | 40 ++++
 rtl/password_lock_ctrl_if.sv | 26 ++
 rtl/password_lock_ctrl_sec_tick.sv | 35 +++
 rtl/password_lock_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/password_lock_ctrl_pkg.sv
// Shared definitions for the password lock session controller: state encodings,
// default timing constants and small helpers also used by the display mux.
package password_lock_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_ENTRY   = 3'd2;
  localparam logic [2:0] ST_OPEN    = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ARM     = ST_ARM,
    ENTRY   = ST_ENTRY,
    OPEN    = ST_OPEN,
    FAIL    = ST_FAIL,
    LOCKOUT = ST_LOCKOUT
  } state_e;

  localparam int CLK_HZ_DEF      = 50_000_000;
  localparam int MAX_FAIL_DEF    = 3;
  localparam int ENTRY_SECS_DEF  = 20;
  localparam int UNLOCK_SECS_DEF = 10;
  localparam int LOCK_SECS_DEF   = 30;

  localparam int FAIL_W = 4;
  localparam int SECS_W = 8;

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v,
                                                input logic [FAIL_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  // States whose residency is measured in whole seconds.
  function automatic logic is_timed(input state_e s);
    return (s == ENTRY) || (s == OPEN) || (s == LOCKOUT);
  endfunction

endpackage

// File: rtl/password_lock_ctrl_if.sv
// Session bus between the password lock controller and the checker/user side.
// master drives requests and checker status, slave is the controller.
interface password_lock_ctrl_if;
  import password_lock_ctrl_pkg::*;

  logic              start;
  logic              chk_good;
  logic              chk_bad;
  logic              chk_clear;
  logic              chk_enable;
  logic              unlocked;
  logic              locked_out;
  logic [FAIL_W-1:0] fail_cnt;
  logic [SECS_W-1:0] lock_remaining;

  modport master (
    output start, chk_good, chk_bad,
    input  chk_clear, chk_enable, unlocked, locked_out, fail_cnt, lock_remaining
  );

  modport slave (
    input  start, chk_good, chk_bad,
    output chk_clear, chk_enable, unlocked, locked_out, fail_cnt, lock_remaining
  );

endinterface

// File: rtl/password_lock_ctrl_sec_tick.sv
// Seconds prescaler: counts 0..CLK_HZ-1 and flags the terminal cycle as a tick.
// restart_i holds the count at 0 so every timed state starts on a fresh second.
module password_lock_ctrl_sec_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/password_lock_ctrl.sv
// Session controller for the 4-digit password checker: arms the checker, gates
// entry, holds the unlock, counts failures and enforces a timed lockout.
module password_lock_ctrl
  import password_lock_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int MAX_FAIL    = MAX_FAIL_DEF,
  parameter int ENTRY_SECS  = ENTRY_SECS_DEF,
  parameter int UNLOCK_SECS = UNLOCK_SECS_DEF,
  parameter int LOCK_SECS   = LOCK_SECS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  password_lock_ctrl_if.slave  bus
);

  if (CLK_HZ < 1) begin : g_bad_clk_hz
    $error("CLK_HZ must be at least 1");
  end
  if ((MAX_FAIL < 1) || (MAX_FAIL > 15)) begin : g_bad_max_fail
    $error("MAX_FAIL must be in 1..15");
  end
  if ((ENTRY_SECS < 1) || (ENTRY_SECS > 255) || (UNLOCK_SECS < 1) || (UNLOCK_SECS > 255)
      || (LOCK_SECS < 1) || (LOCK_SECS > 255)) begin : g_bad_secs
    $error("timed durations must be in 1..255");
  end

  localparam logic [FAIL_W-1:0] MAX_FAIL_V    = FAIL_W'(MAX_FAIL);
  localparam logic [SECS_W-1:0] ENTRY_SECS_V  = SECS_W'(ENTRY_SECS);
  localparam logic [SECS_W-1:0] UNLOCK_SECS_V = SECS_W'(UNLOCK_SECS);
  localparam logic [SECS_W-1:0] LOCK_SECS_V   = SECS_W'(LOCK_SECS);

  state_e            state_q, state_d;
  logic              start_q;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [SECS_W-1:0] timer_q, timer_d;
  logic              chk_clear_q, chk_clear_d;
  logic              chk_enable_q, chk_enable_d;
  logic              unlocked_q, unlocked_d;
  logic              locked_out_q, locked_out_d;
  logic [SECS_W-1:0] lock_rem_q, lock_rem_d;

  logic start_pulse;
  logic tick;
  logic expire;
  logic restart;

  function automatic logic [SECS_W-1:0] load_val(input state_e s);
    case (s)
      ENTRY:   return ENTRY_SECS_V;
      OPEN:    return UNLOCK_SECS_V;
      LOCKOUT: return LOCK_SECS_V;
      default: return '0;
    endcase
  endfunction

  assign start_pulse = bus.start & ~start_q;
  assign expire      = tick & (timer_q == SECS_W'(1));
  // Prescaler restarts on every state change and idles outside timed states.
  assign restart     = (state_d != state_q) | ~is_timed(state_d);

  password_lock_ctrl_sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_pulse) state_d = ARM;
      ARM:     state_d = ENTRY;
      ENTRY: begin
        if (bus.chk_good)     state_d = OPEN;
        else if (bus.chk_bad) state_d = FAIL;
        else if (expire)      state_d = FAIL;
      end
      OPEN:    if (expire) state_d = IDLE;
      FAIL:    state_d = (fail_cnt_q == MAX_FAIL_V) ? LOCKOUT : IDLE;
      LOCKOUT: if (expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if ((state_q == ENTRY) && (state_d == FAIL)) begin
      fail_cnt_d = sat_inc(fail_cnt_q, MAX_FAIL_V);
    end else if ((state_d == OPEN) && (state_q != OPEN)) begin
      fail_cnt_d = '0;
    end else if ((state_q == LOCKOUT) && (state_d == IDLE)) begin
      fail_cnt_d = '0;
    end

    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = load_val(state_d);
    end else if (is_timed(state_q) && tick) begin
      timer_d = timer_q - 1'b1;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    chk_clear_d  = (state_d == ARM) ||
                   ((state_d == IDLE) && ((state_q == OPEN) || (state_q == LOCKOUT)));
    chk_enable_d = (state_d == ENTRY);
    unlocked_d   = (state_d == OPEN);
    locked_out_d = (state_d == LOCKOUT);
    lock_rem_d   = (state_d == LOCKOUT) ? timer_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      fail_cnt_q   <= '0;
      timer_q      <= '0;
      chk_clear_q  <= 1'b0;
      chk_enable_q <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      lock_rem_q   <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= bus.start;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      chk_clear_q  <= chk_clear_d;
      chk_enable_q <= chk_enable_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      lock_rem_q   <= lock_rem_d;
    end
  end

  assign bus.chk_clear      = chk_clear_q;
  assign bus.chk_enable     = chk_enable_q;
  assign bus.unlocked       = unlocked_q;
  assign bus.locked_out     = locked_out_q;
  assign bus.fail_cnt       = fail_cnt_q;
  assign bus.lock_remaining = lock_rem_q;

endmodule
